// File: rtl/times_table_arbiter.sv
// Round-robin sequencer sharing one times-table read port (a*b) between NUM_REQ requesters.
// Optional macro MULT_CHECK_EN adds a sticky product-mismatch flag on o_err.
module times_table_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    output logic [NUM_REQ-1:0]     o_req_ready,
    input  logic [3*NUM_REQ-1:0]   i_req_a,
    input  logic [3*NUM_REQ-1:0]   i_req_b,
    output logic [NUM_REQ-1:0]     o_rsp_valid,
    output logic [5:0]             o_rsp_result,
    output logic                   o_mem_read,
    output logic [2:0]             o_mem_a,
    output logic [2:0]             o_mem_b,
    input  logic [5:0]             i_mem_result,
    output logic                   o_err
);

    localparam int                IDX_W    = $clog2(NUM_REQ);
    localparam int                CNT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_mem_read;
    logic [2:0]           r_mem_a;
    logic [2:0]           r_mem_b;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [5:0]           r_rsp_result;

    logic [2:0]           w_opnd_a [NUM_REQ];
    logic [2:0]           w_opnd_b [NUM_REQ];
    logic                 w_found;
    logic [IDX_W-1:0]     w_winner;
    logic [IDX_W-1:0]     w_cand;
    logic [IDX_W-1:0]     w_next_ptr;
    logic                 w_grant;
    logic                 w_capture;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_opnd_a[i] = i_req_a[3*i +: 3];
            w_opnd_b[i] = i_req_b[3*i +: 3];
        end
    end

    // Scan requesters starting at r_rr_ptr; the first valid one wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && i_req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
            w_cand = (w_cand == LAST_IDX) ? '0 : w_cand + 1'b1;
        end
    end

    assign w_next_ptr = (w_winner == LAST_IDX) ? '0 : w_winner + 1'b1;
    assign w_grant    = (r_state == S_IDLE) && w_found && !rst;
    assign w_capture  = (r_state == S_WAIT) && (r_cnt == '0);

    always_comb begin
        o_req_ready = '0;
        if (w_grant) o_req_ready[w_winner] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_mem_read   <= 1'b0;
            r_mem_a      <= '0;
            r_mem_b      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
        end else begin
            // NOTE: non-blocking updates; the pulse defaults below are overridden later in the same edge.
            r_mem_read  <= 1'b0;
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_idx      <= w_winner;
                        r_mem_a    <= w_opnd_a[w_winner];
                        r_mem_b    <= w_opnd_b[w_winner];
                        r_rr_ptr   <= w_next_ptr;
                        r_mem_read <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= CNT_W'(RD_LATENCY - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_capture) begin
                        r_rsp_result       <= i_mem_result;
                        r_rsp_valid[r_idx] <= 1'b1;
                        r_state            <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_read   = r_mem_read;
    assign o_mem_a      = r_mem_a;
    assign o_mem_b      = r_mem_b;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_rsp_result;

`ifdef MULT_CHECK_EN
    logic       r_err;
    logic [5:0] w_product;

    assign w_product = {3'b000, r_mem_a} * {3'b000, r_mem_b};

    // Compared on the same edge that captures the result, so the check costs no latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_capture && (i_mem_result != w_product)) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_times_table_arbiter.sv
// Self-checking bench for times_table_arbiter: scoreboarded RD_LATENCY=1 instance plus a RD_LATENCY=3 instance.
module tb_times_table_arbiter;

    localparam int NR = 4;

    typedef struct {
        int         idx;
        logic [2:0] a;
        logic [2:0] b;
        logic [5:0] res;
        int         acc_cyc;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NR-1:0]   req_valid0, req_ready0, rsp_valid0;
    logic [3*NR-1:0] req_a0, req_b0;
    logic [5:0]      rsp_result0, mem_result0;
    logic            mem_read0, err0;
    logic [2:0]      mem_a0, mem_b0;

    logic [NR-1:0]   req_valid1, req_ready1, rsp_valid1;
    logic [3*NR-1:0] req_a1, req_b1;
    logic [5:0]      rsp_result1, mem_result1;
    logic            mem_read1, err1;
    logic [2:0]      mem_a1, mem_b1;

    times_table_arbiter #(.NUM_REQ(NR), .RD_LATENCY(1)) dut0 (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid0), .o_req_ready(req_ready0),
        .i_req_a(req_a0), .i_req_b(req_b0),
        .o_rsp_valid(rsp_valid0), .o_rsp_result(rsp_result0),
        .o_mem_read(mem_read0), .o_mem_a(mem_a0), .o_mem_b(mem_b0),
        .i_mem_result(mem_result0), .o_err(err0)
    );

    times_table_arbiter #(.NUM_REQ(NR), .RD_LATENCY(3)) dut1 (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid1), .o_req_ready(req_ready1),
        .i_req_a(req_a1), .i_req_b(req_b1),
        .o_rsp_valid(rsp_valid1), .o_rsp_result(rsp_result1),
        .o_mem_read(mem_read1), .o_mem_a(mem_a1), .o_mem_b(mem_b1),
        .i_mem_result(mem_result1), .o_err(err1)
    );

    // Times-table memory; deliberately returns 20 for 4*4 to provoke the mismatch flag.
    function automatic logic [5:0] mem_fn(input logic [2:0] a, input logic [2:0] b);
        if (a == 3'd4 && b == 3'd4) return 6'd20;
        return {3'b000, a} * {3'b000, b};
    endfunction

    logic [5:0] m0_stage;
    logic [5:0] m1_pipe [3];
    always @(posedge clk) begin
        if (rst) begin
            m0_stage   <= '0;
            m1_pipe[0] <= '0;
            m1_pipe[1] <= '0;
            m1_pipe[2] <= '0;
        end else begin
            m0_stage   <= mem_read0 ? mem_fn(mem_a0, mem_b0) : 6'd0;
            m1_pipe[0] <= mem_read1 ? mem_fn(mem_a1, mem_b1) : 6'd0;
            m1_pipe[1] <= m1_pipe[0];
            m1_pipe[2] <= m1_pipe[1];
        end
    end
    assign mem_result0 = m0_stage;
    assign mem_result1 = m1_pipe[2];

    int n_cmp    = 0;
    int n_err    = 0;
    int n_accept = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    txn_t       sb [$];
    int         exp_grant [$];
    int         rsp_cycs [$];
    logic [5:0] last_res;
    logic       err_exp;
    logic       prev_mem_read;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor for dut0: grants, memory strobe, responses, result hold and err flag.
    always @(negedge clk) begin : mon0
        logic [NR-1:0] acc;
        txn_t          t;
        if (rst) begin
            sb.delete();
            last_res      = '0;
            err_exp       = 1'b0;
            prev_mem_read = 1'b0;
        end else begin
            acc = req_ready0 & req_valid0;
            chk("ready_onehot0", 32'($onehot0(req_ready0)), 1);
            if (acc != '0) begin
                n_accept++;
                if (exp_grant.size() == 0) begin
                    chk("unexpected_grant", 32'(acc), 0);
                end else begin
                    t.idx     = exp_grant.pop_front();
                    chk("grant", 32'(acc), 1 << t.idx);
                    t.a       = req_a0[3*t.idx +: 3];
                    t.b       = req_b0[3*t.idx +: 3];
                    t.res     = mem_fn(t.a, t.b);
                    t.acc_cyc = cyc;
                    sb.push_back(t);
                end
            end
            if (mem_read0) begin
                chk("mem_read_width", 32'(prev_mem_read), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_mem_read", 32'(mem_read0), 0);
                end else begin
                    chk("mem_read_lat", cyc - sb[0].acc_cyc, 1);
                    chk("mem_a", 32'(mem_a0), 32'(sb[0].a));
                    chk("mem_b", 32'(mem_b0), 32'(sb[0].b));
                end
            end
            prev_mem_read = mem_read0;
            if (rsp_valid0 != '0) begin
                rsp_cycs.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid0), 0);
                end else begin
                    t = sb.pop_front();
                    chk("rsp_onehot", 32'(rsp_valid0), 1 << t.idx);
                    chk("rsp_result", 32'(rsp_result0), 32'(t.res));
                    chk("rsp_latency", cyc - t.acc_cyc, 3);
`ifdef MULT_CHECK_EN
                    if (t.res != ({3'b000, t.a} * {3'b000, t.b})) err_exp = 1'b1;
`endif
                    last_res = t.res;
                end
            end else begin
                chk("rsp_hold", 32'(rsp_result0), 32'(last_res));
            end
            chk("err", 32'(err0), 32'(err_exp));
        end
    end

    task automatic set_op(input int idx, input logic [2:0] a, input logic [2:0] b);
        req_a0[3*idx +: 3] = a;
        req_b0[3*idx +: 3] = b;
    endtask

    task automatic wait_accepts(input int n, input int budget);
        int target;
        target = n_accept + n;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (n_accept >= target) return;
        end
        chk("accept_timeout", n_accept, target);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && exp_grant.size() == 0) return;
        end
        chk("idle_timeout", sb.size(), 0);
    endtask

    task automatic do_req(input int idx, input logic [2:0] a, input logic [2:0] b);
        exp_grant.push_back(idx);
        set_op(idx, a, b);
        req_valid0[idx] = 1'b1;
        wait_accepts(1, 20);
        req_valid0[idx] = 1'b0;
        wait_idle(20);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_c, lat, nread, base;
        logic found;

        rst        = 1'b1;
        req_valid0 = '1;
        req_valid1 = '1;
        req_a0     = '0;
        req_b0     = '0;
        req_a1     = '0;
        req_b1     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 32'(req_ready0), 0);
        chk("rst_ready1", 32'(req_ready1), 0);
        chk("rst_rsp_valid", 32'(rsp_valid0), 0);
        chk("rst_rsp_result", 32'(rsp_result0), 0);
        chk("rst_mem_read", 32'(mem_read0), 0);
        chk("rst_mem_a", 32'(mem_a0), 0);
        chk("rst_mem_b", 32'(mem_b0), 0);
        chk("rst_err", 32'(err0), 0);
        @(posedge clk); #1;
        req_valid0 = '0;
        req_valid1 = '0;
        rst        = 1'b0;

        // All requesters valid: strict round robin from pointer 0, wrapping back to 0.
        for (int i = 0; i < NR; i++) set_op(i, 3'(i + 1), 3'd7);
        exp_grant = '{0, 1, 2, 3, 0};
        rsp_cycs.delete();
        req_valid0 = '1;
        wait_accepts(5, 40);
        req_valid0 = '0;
        wait_idle(20);
        chk("t2_rsp_count", rsp_cycs.size(), 5);
        for (int i = 1; i < 5 && i < rsp_cycs.size(); i++)
            chk("t2_rsp_gap", rsp_cycs[i] - rsp_cycs[i-1], 4);

        // Single request 3*5 while requester 3 pulses valid only during the busy phase.
        base = n_accept;
        exp_grant.push_back(0);
        set_op(0, 3'd3, 3'd5);
        req_valid0[0] = 1'b1;
        wait_accepts(1, 20);
        req_valid0[0] = 1'b0;
        set_op(3, 3'd1, 3'd1);
        req_valid0[3] = 1'b1;
        @(posedge clk); #1;
        req_valid0[3] = 1'b0;
        wait_idle(20);
        repeat (2) @(posedge clk);
        #1 chk("t1_accept_count", n_accept - base, 1);

        // Boundary operands; pointer wraps after requester 3.
        do_req(1, 3'd7, 3'd7);
        do_req(3, 3'd0, 3'd6);

        // Faulty memory answer for 4*4.
        do_req(2, 3'd4, 3'd4);
        do_req(1, 3'd2, 3'd3);

        // Reset while requester 2 is waiting on memory.
        exp_grant.push_back(2);
        set_op(2, 3'd5, 3'd5);
        req_valid0[2] = 1'b1;
        wait_accepts(1, 20);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t4_ready", 32'(req_ready0), 0);
        chk("t4_rsp_valid", 32'(rsp_valid0), 0);
        chk("t4_rsp_result", 32'(rsp_result0), 0);
        chk("t4_mem_read", 32'(mem_read0), 0);
        chk("t4_mem_a", 32'(mem_a0), 0);
        chk("t4_mem_b", 32'(mem_b0), 0);
        chk("t4_err", 32'(err0), 0);
        req_valid0 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_grant.push_back(1);
        exp_grant.push_back(3);
        set_op(1, 3'd3, 3'd4);
        set_op(3, 3'd2, 3'd2);
        req_valid0[1] = 1'b1;
        req_valid0[3] = 1'b1;
        wait_accepts(1, 20);
        req_valid0[1] = 1'b0;
        wait_accepts(1, 20);
        req_valid0[3] = 1'b0;
        wait_idle(20);

        // RD_LATENCY=3 instance: 6*2.
        req_a1[2:0]   = 3'd6;
        req_b1[2:0]   = 3'd2;
        req_valid1[0] = 1'b1;
        found = 1'b0;
        acc_c = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (req_ready1[0]) begin
                found = 1'b1;
                acc_c = cyc;
            end
        end
        chk("t6_accept", 32'(found), 1);
        @(posedge clk); #1;
        req_valid1 = '0;
        found = 1'b0;
        nread = 0;
        lat   = -1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mem_read1) nread++;
            if (rsp_valid1 != '0) begin
                found = 1'b1;
                lat   = cyc - acc_c;
                chk("t6_rsp_onehot", 32'(rsp_valid1), 1);
                chk("t6_rsp_result", 32'(rsp_result1), 12);
            end
        end
        chk("t6_rsp_seen", 32'(found), 1);
        chk("t6_latency", lat, 5);
        chk("t6_mem_read_cycles", nread, 1);
        chk("t6_err", 32'(err1), 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
